// File: rtl/diaosi_types_pkg.sv
// Shared types for the diaosi pipeline: next-PC select encoding and the
// pipeline-controller state.
// Purely declarative; no logic.
package diaosi_types_pkg;

  // Next-PC select carried down the pipe; anything but ADD4 is a redirect.
  typedef enum logic [1:0] {
    ADD4_DIAOSI   = 2'd0,
    BRANCH_DIAOSI = 2'd1,
    JUMP_DIAOSI   = 2'd2,
    JR_DIAOSI     = 2'd3
  } pcsrc_t;

  // Pipeline controller states.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } pctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an IF/ID source that matches an ID/EX load.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the controller decides what to do with the flag.
module hazard_detect (
  input  logic       d_ren_o2,
  input  logic [4:0] wsel_o2,
  input  logic [4:0] rs_o1,
  input  logic [4:0] rt_o1,
  output logic       load_use
);

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign load_use = d_ren_o2 && (wsel_o2 != 5'd0) &&
                    ((wsel_o2 == rs_o1) || (wsel_o2 == rt_o1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stage enables, bubble inserts, dmem gating, halt, perf counters.
// Latency: enables/flushes are combinational from state and inputs; state and counters update on CLK.
// Backpressure: a pending data access without dhit freezes every stage until dhit arrives.
module pipe_ctrl
  import diaosi_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             d_ren_o3,
  input  logic             d_wen_o3,
  input  pcsrc_t           PCSrc_o3,
  input  logic             halt_o3,
  input  logic             d_ren_o2,
  input  logic [4:0]       wsel_o2,
  input  logic [4:0]       rs_o1,
  input  logic [4:0]       rt_o1,
  output logic             pc_en,
  output logic             pipe1_en,
  output logic             pipe2_en,
  output logic             pipe3_en,
  output logic             pipe4_en,
  output logic             flush1,
  output logic             flush2,
  output logic             flush3,
  output logic             dmem_ren,
  output logic             dmem_wen,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pctrl_state_t state;
  pctrl_state_t state_nxt;

  logic       mem_busy;
  logic       redirect;
  logic       load_use;
  logic [4:0] en;   // {pc, pipe1, pipe2, pipe3, pipe4}
  logic [2:0] fl;   // {flush1, flush2, flush3}

  assign mem_busy = d_ren_o3 | d_wen_o3;
  assign redirect = (PCSrc_o3 != ADD4_DIAOSI);

  hazard_detect u_hazard_detect (
    .d_ren_o2 (d_ren_o2),
    .wsel_o2  (wsel_o2),
    .rs_o1    (rs_o1),
    .rt_o1    (rt_o1),
    .load_use (load_use)
  );

  assign {pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en} = en;
  assign {flush1, flush2, flush3} = fl;

  // Enables, flushes, dmem gating and next state; everything is forced low during reset.
  always_comb begin
    en        = 5'b00000;
    fl        = 3'b000;
    dmem_ren  = 1'b0;
    dmem_wen  = 1'b0;
    halt      = 1'b0;
    state_nxt = state;
    if (!RST) begin
      dmem_ren = d_ren_o3;
      dmem_wen = d_wen_o3;
      case (state)
        RUN: begin
          if (halt_o3) begin
            halt      = 1'b1;
            state_nxt = HALTED;
          end else if (mem_busy && !dhit) begin
            state_nxt = MEM_WAIT;
          end else if (redirect) begin
            en = 5'b11111;
            fl = 3'b111;
          end else if (load_use) begin
            // Hold PC and IF/ID, bubble into ID/EX so the load can retire.
            en = 5'b00111;
            fl = 3'b010;
          end else if (!ihit) begin
            // Hold PC, let older instructions drain, bubble into IF/ID.
            en = 5'b01111;
            fl = 3'b100;
          end else begin
            en = 5'b11111;
          end
        end
        MEM_WAIT: begin
          if (dhit) begin
            en        = 5'b11111;
            state_nxt = RUN;
          end
        end
        HALTED: begin
          halt     = 1'b1;
          dmem_ren = 1'b0;
          dmem_wen = 1'b0;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // State register and saturating stall/flush counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if ((state != HALTED) && !pc_en && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((|fl) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of each performance counter.
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port ihit  input  1  instruction fetch completed this cycle.
REQ-005 SHALL have port dhit  input  1  data access completed this cycle.
REQ-006 SHALL have port d_ren_o3, d_wen_o3  input  1 each  EX/MEM memory read/write request.
REQ-007 SHALL have port PCSrc_o3  input  PCSrc type  EX/MEM next-PC select; non-ADD4_DIAOSI means redirect.
REQ-008 SHALL have port halt_o3  input  1  halt instruction in MEM stage.
REQ-009 SHALL have port d_ren_o2  input  1  ID/EX instruction is a load.
REQ-010 SHALL have ports wsel_o2, rs_o1, rt_o1  input  5 each  ID/EX destination, IF/ID sources.
REQ-011 SHALL have ports pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en  output  1 each  PC and IF/ID, ID/EX, EX/MEM, MEM/WB load enables.
REQ-012 SHALL have ports flush1, flush2, flush3  output  1 each  bubble-insert into IF/ID, ID/EX, EX/MEM.
REQ-013 SHALL have ports dmem_ren, dmem_wen  output  1 each  gated data-memory requests.
REQ-014 SHALL have port halt  output  1  sticky halted indication.
REQ-015 SHALL have ports stall_cnt, flush_cnt  output  CNT_W each  saturating performance counters.

Function
REQ-016 SHALL implement FSM states RUN, MEM_WAIT, HALTED; all enable/flush outputs combinational from state and inputs.
REQ-017 SHALL define mem_busy = d_ren_o3 | d_wen_o3; load_use = d_ren_o2 & (wsel_o2 != 0) & (wsel_o2 == rs_o1 | wsel_o2 == rt_o1); redirect = PCSrc_o3 != ADD4_DIAOSI.
REQ-018 SHALL, in RUN, apply priority halt_o3 > (mem_busy & !dhit) > redirect > load_use > !ihit > normal.
REQ-019 SHALL, in RUN with halt_o3, drive all enables 0, assert halt, go to HALTED next cycle.
REQ-020 SHALL, in RUN with mem_busy & !dhit, drive all enables 0, no flush, go to MEM_WAIT.
REQ-021 SHALL, in MEM_WAIT, hold all enables 0 while !dhit; on dhit drive all enables 1 that cycle and return to RUN.
REQ-022 SHALL, in RUN with redirect, drive pc_en and pipe1..4_en 1 and flush1..3 1 for that cycle only.
REQ-023 SHALL, in RUN with load_use, drive pc_en=0, pipe1_en=0, flush2=1, pipe2..4_en=1.
REQ-024 SHALL, in RUN with !ihit (no higher condition), drive pc_en=0, flush1=1, pipe1..4_en=1.
REQ-025 SHALL, in RUN normal, drive all enables 1, all flushes 0.
REQ-026 SHALL drive dmem_ren=d_ren_o3, dmem_wen=d_wen_o3 except in HALTED, where both are 0.
REQ-027 SHALL remain in HALTED until RST, with all enables 0 and halt=1.
REQ-028 SHALL increment stall_cnt each cycle pc_en=0 outside HALTED, and flush_cnt each cycle any flush is 1; both saturate at all-ones.

Reset
REQ-029 SHALL, while RST=1 at a clock edge, set state RUN, halt 0, stall_cnt 0, flush_cnt 0.
REQ-030 SHALL, during any cycle with RST=1, drive all enables, flushes and dmem requests 0.
REQ-031 SHALL abandon MEM_WAIT or HALTED on RST with no residual output next cycle.

Structure
REQ-032 SHALL add state enum pctrl_state_t to diaosi_types_pkg; PCSrc type and ADD4_DIAOSI come from that package.
REQ-033 SHALL place the load_use comparison in a combinational sub-module hazard_detect.

Verification
REQ-034 SHALL cover: d_ren_o3=1, dhit low 3 cycles then high -> enables 0 for 3 cycles, all 1 on dhit cycle, stall_cnt=3.
REQ-035 SHALL cover: d_ren_o2=1, wsel_o2=8, rs_o1=8 -> pc_en=0, pipe1_en=0, flush2=1 for one cycle; wsel_o2=0 -> no stall.
REQ-036 SHALL cover: PCSrc_o3=branch with ihit=0 -> flush1..3=1, pc_en=1, flush_cnt +1.
REQ-037 SHALL cover: halt_o3=1 with load_use=1 -> HALTED, all enables 0, dmem_ren=0 while d_ren_o3=1, halt sticky until RST.
REQ-038 SHALL cover: RST=1 mid-MEM_WAIT -> next cycle RUN, counters 0, outputs 0 during reset cycle.
REQ-039 SHALL cover: CNT_W=4, 20 stall cycles -> stall_cnt holds 15.
